// File: rtl/key_matrix_scan.sv
// Purpose : 4x4 active-low key matrix scanner; debounces whole 16-key frames and emits press/release events.
// Latency : press-to-event at most (DEBOUNCE_SCANS+1)*4*DWELL + 4 cycles; at most one event per cycle.
// Backpr. : key_valid holds key_code/key_press stable until key_ready; scanning is paused while events wait.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   row_n[3:0]      row drive, active-low, at most one bit low (all high while paused or in reset)
//   col_n[3:0]      column sense, active-low, asynchronous to clk
//   key_valid/ready event handshake
//   key_code[3:0]   key index = row*4 + col
//   key_press       1 = press, 0 = release
//   key_down[15:0]  debounced key state bitmap
module key_matrix_scan #(
    parameter int N              = 32,
    parameter int FREQ           = 60,
    parameter int SCAN_US        = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  row_n,
    input  logic [3:0]  col_n,
    output logic        key_valid,
    input  logic        key_ready,
    output logic [3:0]  key_code,
    output logic        key_press,
    output logic [15:0] key_down
);

    localparam int            DWELL      = SCAN_US * FREQ;
    localparam logic [N-1:0]  DWELL_LAST = N'(DWELL - 1);
    localparam int            CW         = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_SCANS);

    localparam logic [1:0] ST_SCAN   = 2'd0;
    localparam logic [1:0] ST_COMMIT = 2'd1;
    localparam logic [1:0] ST_EMIT   = 2'd2;

    logic [3:0]    col_s1_q, col_s2_q;
    logic [3:0]    raw;
    logic          drive_q;
    logic [1:0]    state_q, state_d;
    logic [N-1:0]  timer_q, timer_d;
    logic [1:0]    row_q, row_d;
    logic [15:0]   frame_q, frame_d;
    logic [15:0]   prev_frame_q, prev_frame_d;
    logic [CW-1:0] stable_cnt_q, stable_cnt_d;
    logic [15:0]   accepted_q, accepted_d;
    logic [15:0]   pending_q, pending_d;
    logic [15:0]   key_down_q, key_down_d;
    logic [3:0]    code_w;
    logic          press_w;
    logic [15:0]   code_sel;

    assign raw = ~col_s2_q;

    // drive_q stays low for the first cycle after reset so row_n is high
    // throughout reset and row 0 then gets a full dwell.
    assign row_n     = (state_q == ST_SCAN && drive_q) ? ~(4'b0001 << row_q) : 4'hF;
    assign key_valid = (state_q == ST_EMIT);
    assign key_code  = key_valid ? code_w  : 4'd0;
    assign key_press = key_valid ? press_w : 1'b0;
    assign key_down  = key_down_q;

    // Lowest set pending bit goes first, giving ascending key_code order.
    always_comb begin
        code_w = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (pending_q[i]) code_w = 4'(i);
        end
    end

    assign press_w  = accepted_q[code_w];
    assign code_sel = 16'd1 << code_w;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        row_d        = row_q;
        frame_d      = frame_q;
        prev_frame_d = prev_frame_q;
        stable_cnt_d = stable_cnt_q;
        accepted_d   = accepted_q;
        pending_d    = pending_q;
        key_down_d   = key_down_q;

        case (state_q)
            ST_SCAN: begin
                if (drive_q) begin
                    if (timer_q == DWELL_LAST) begin
                        timer_d = '0;
                        row_d   = row_q + 2'd1;
                        frame_d[{row_q, 2'b00} +: 4] = raw;
                        if (row_q == 2'd3) begin
                            if (frame_d != prev_frame_q) begin
                                prev_frame_d = frame_d;
                                stable_cnt_d = CW'(1);
                            end else if (stable_cnt_q < CNT_MAX) begin
                                stable_cnt_d = stable_cnt_q + CW'(1);
                            end
                            if (stable_cnt_d == CNT_MAX && frame_d != key_down_q) begin
                                accepted_d = frame_d;
                                state_d    = ST_COMMIT;
                            end
                        end
                    end else begin
                        timer_d = timer_q + N'(1);
                    end
                end
            end
            ST_COMMIT: begin
                pending_d = accepted_q ^ key_down_q;
                state_d   = ST_EMIT;
            end
            ST_EMIT: begin
                if (key_ready) begin
                    key_down_d[code_w] = press_w;
                    pending_d          = pending_q & ~code_sel;
                    if ((pending_q & ~code_sel) == 16'd0) begin
                        state_d = ST_SCAN;
                        row_d   = 2'd0;
                        timer_d = '0;
                    end
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_s1_q     <= 4'hF;
            col_s2_q     <= 4'hF;
            drive_q      <= 1'b0;
            state_q      <= ST_SCAN;
            timer_q      <= '0;
            row_q        <= 2'd0;
            frame_q      <= 16'd0;
            prev_frame_q <= 16'd0;
            stable_cnt_q <= '0;
            accepted_q   <= 16'd0;
            pending_q    <= 16'd0;
            key_down_q   <= 16'd0;
        end else begin
            col_s1_q     <= col_n;
            col_s2_q     <= col_s1_q;
            drive_q      <= 1'b1;
            state_q      <= state_d;
            timer_q      <= timer_d;
            row_q        <= row_d;
            frame_q      <= frame_d;
            prev_frame_q <= prev_frame_d;
            stable_cnt_q <= stable_cnt_d;
            accepted_q   <= accepted_d;
            pending_q    <= pending_d;
            key_down_q   <= key_down_d;
        end
    end

endmodule

// File: tb/tb_key_matrix_scan.sv
// Purpose : self-checking bench for key_matrix_scan with a keypad model and an event scoreboard.
// Latency : DWELL=4 cycles, 16-cycle frames, two identical frames to accept.
// Backpr. : key_ready driven per scenario; expected events queued at stimulus, popped on handshake.
module tb_key_matrix_scan;

    typedef struct packed {
        logic [3:0] code;
        logic       press;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic        key_valid;
    logic        key_ready = 1'b1;
    logic [3:0]  key_code;
    logic        key_press;
    logic [15:0] key_down;

    logic [15:0] held   = 16'd0;
    logic        glitch = 1'b0;
    ev_t         exp_q[$];
    logic [15:0] model_down = 16'd0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          ev_cnt = 0;
    int          phase = 0;
    logic [3:0]  last_row = 4'hF;
    logic        prev_stall = 1'b0;
    logic [3:0]  prev_code = 4'd0;
    logic        prev_press = 1'b0;

    key_matrix_scan #(
        .N(32), .FREQ(1), .SCAN_US(4), .DEBOUNCE_SCANS(2)
    ) dut (
        .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n),
        .key_valid(key_valid), .key_ready(key_ready),
        .key_code(key_code), .key_press(key_press), .key_down(key_down)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_ev(input logic [3:0] code, input logic press);
        ev_t e;
        e.code  = code;
        e.press = press;
        exp_q.push_back(e);
    endtask

    // Keypad: a held key pulls its column low while its row is driven.
    // The glitch pattern on key 0 is low for the synchronised view of
    // dwell cycles 0..2 of row 0 and high where the DUT samples.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!row_n[r]) begin
                for (int c = 0; c < 4; c++) begin
                    if (held[r*4 + c]) col_n[c] = 1'b0;
                end
            end
        end
        if (glitch && ((row_n == 4'b0111 && phase >= 2) || (row_n == 4'b1110 && phase == 0)))
            col_n[0] = 1'b0;
    end

    // Monitor: protocol rules every cycle, scoreboard pop on handshake.
    always @(negedge clk) begin
        ev_t e;
        if (row_n != last_row) phase = 0;
        else if (phase < 1000) phase++;
        last_row = row_n;
        chk("row_onehot", {31'd0, ($countones(~row_n) <= 1)}, 32'd1);
        if (rst) begin
            model_down = 16'd0;
            prev_stall = 1'b0;
            chk("key_down", {16'd0, key_down}, {16'd0, model_down});
        end else begin
            chk("key_down", {16'd0, key_down}, {16'd0, model_down});
            if (key_valid) chk("row_idle_in_emit", {28'd0, row_n}, 32'hF);
            if (prev_stall) begin
                chk("valid_held", {31'd0, key_valid}, 32'd1);
                chk("code_stable", {28'd0, key_code}, {28'd0, prev_code});
                chk("press_stable", {31'd0, key_press}, {31'd0, prev_press});
            end
            if (key_valid && key_ready) begin
                ev_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", {31'd0, key_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ev_code", {28'd0, key_code}, {28'd0, e.code});
                    chk("ev_press", {31'd0, key_press}, {31'd0, e.press});
                    model_down[e.code] = e.press;
                end
            end
            prev_stall = key_valid && !key_ready;
            prev_code  = key_code;
            prev_press = key_press;
        end
    end

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !key_valid) break;
        end
        chk(tag, exp_q.size(), 32'd0);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (key_valid) break;
        end
        chk(tag, {31'd0, key_valid}, 32'd1);
    endtask

    task automatic wait_row0(input string tag);
        logic [3:0] prev;
        logic       seen;
        prev = row_n;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (row_n == 4'b1110 && prev != 4'b1110) begin
                seen = 1'b1;
                break;
            end
            prev = row_n;
        end
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic drive_held(input logic [15:0] v);
        @(posedge clk);
        #1;
        held = v;
    endtask

    initial begin
        int ev0;
        logic [3:0] er;

        // 1. Reset values, then the free-running row pattern.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_row_n", {28'd0, row_n}, 32'hF);
        chk("rst_valid", {31'd0, key_valid}, 32'd0);
        chk("rst_code", {28'd0, key_code}, 32'd0);
        chk("rst_press", {31'd0, key_press}, 32'd0);
        chk("rst_down", {16'd0, key_down}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            er = ~(4'b0001 << ((k / 4) % 4));
            chk("scan_row_n", {28'd0, row_n}, {28'd0, er});
            chk("scan_idle_valid", {31'd0, key_valid}, 32'd0);
        end

        // 2. Press and release key 6.
        push_ev(4'd6, 1'b1);
        drive_held(16'h0040);
        drain("t2_press_drain", 120);
        chk("t2_down_press", {16'd0, key_down}, 32'h0040);
        push_ev(4'd6, 1'b0);
        drive_held(16'h0000);
        drain("t2_release_drain", 120);
        chk("t2_down_release", {16'd0, key_down}, 32'h0);

        // 3. Bouncing frames produce nothing; a steady hold produces one press.
        ev0 = ev_cnt;
        for (int f = 0; f < 4; f++) begin
            wait_row0("t3_frame_start");
            held = (f % 2 == 0) ? 16'h0040 : 16'h0000;
        end
        wait_row0("t3_hold_start");
        chk("t3_no_event_while_bouncing", ev_cnt - ev0, 32'd0);
        push_ev(4'd6, 1'b1);
        held = 16'h0040;
        drain("t3_press_drain", 120);
        chk("t3_one_event", ev_cnt - ev0, 32'd1);
        push_ev(4'd6, 1'b0);
        drive_held(16'h0000);
        drain("t3_release_drain", 120);

        // 4. Two keys in one frame under backpressure.
        push_ev(4'd0, 1'b1);
        push_ev(4'd15, 1'b1);
        @(posedge clk);
        #1;
        key_ready = 1'b0;
        held = 16'h8001;
        wait_valid("t4_valid_seen", 120);
        for (int i = 0; i < 10; i++) begin
            chk("t4_stall_valid", {31'd0, key_valid}, 32'd1);
            chk("t4_stall_code", {28'd0, key_code}, 32'd0);
            chk("t4_stall_row_n", {28'd0, row_n}, 32'hF);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        key_ready = 1'b1;
        @(negedge clk);
        chk("t4_first_code", {28'd0, key_code}, 32'd0);
        chk("t4_first_valid", {31'd0, key_valid}, 32'd1);
        @(negedge clk);
        chk("t4_second_code", {28'd0, key_code}, 32'd15);
        chk("t4_second_valid", {31'd0, key_valid}, 32'd1);
        chk("t4_second_press", {31'd0, key_press}, 32'd1);
        @(negedge clk);
        chk("t4_done_valid", {31'd0, key_valid}, 32'd0);
        chk("t4_done_row_n", {28'd0, row_n}, 32'hE);
        chk("t4_down", {16'd0, key_down}, 32'h8001);
        push_ev(4'd0, 1'b0);
        push_ev(4'd15, 1'b0);
        drive_held(16'h0000);
        drain("t4_release_drain", 120);

        // 5. Reset while an event is waiting; the held key is re-reported.
        push_ev(4'd6, 1'b1);
        @(posedge clk);
        #1;
        key_ready = 1'b0;
        held = 16'h0040;
        wait_valid("t5_valid_seen", 120);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("t5_rst_valid", {31'd0, key_valid}, 32'd0);
        chk("t5_rst_down", {16'd0, key_down}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        key_ready = 1'b1;
        push_ev(4'd6, 1'b1);
        drain("t5_repress_drain", 150);
        chk("t5_down", {16'd0, key_down}, 32'h0040);
        push_ev(4'd6, 1'b0);
        drive_held(16'h0000);
        drain("t5_release_drain", 120);

        // 6. Column activity outside the sample cycle is ignored.
        ev0 = ev_cnt;
        @(posedge clk);
        #1;
        glitch = 1'b1;
        repeat (100) @(negedge clk);
        chk("t6_no_event", ev_cnt - ev0, 32'd0);
        chk("t6_down", {16'd0, key_down}, 32'd0);
        @(posedge clk);
        #1;
        glitch = 1'b0;
        repeat (40) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
